// File: rtl/ifu.sv
// Instruction fetch unit: issues one outstanding imem read for the current pc
// and hands the instruction to decode over a valid/ready interface.
module ifu #(
  parameter int CPU_WIDTH  = 64,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CPU_WIDTH-1:0]  pc,
  input  logic                  flush,
  output logic                  pc_hold,
  output logic                  imem_req,
  output logic [CPU_WIDTH-1:0]  imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  imem_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0]  inst_pc,
  output logic                  inst_fault
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP,
    HOLD
  } state_e;

  state_e                  state_q, state_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic [CPU_WIDTH-1:0]    inst_pc_q, inst_pc_d;
  logic                    inst_fault_q, inst_fault_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    imem_req     = 1'b0;
    imem_addr    = '0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_addr = pc;
        // A misaligned pc never reaches memory; it becomes a faulting instruction.
        if (pc[1:0] != 2'b00) begin
          state_d      = HOLD;
          inst_d       = '0;
          inst_pc_d    = pc;
          inst_fault_d = 1'b1;
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            inst_pc_d = pc;
            state_d   = flush ? DROP : WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (flush) begin
            state_d = REQ;
          end else begin
            inst_d       = imem_err ? '0 : imem_rdata;
            inst_fault_d = imem_err;
            state_d      = HOLD;
          end
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = REQ;
      end
      HOLD: begin
        if (flush || inst_ready) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  assign inst_valid = (state_q == HOLD);
  assign pc_hold    = ~(inst_valid & inst_ready) & ~flush;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios followed by a randomized run
// against a memory model and a pc-indexed reference of expected instructions.
module tb_ifu;

  localparam logic [63:0] P = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc = P;
  logic        flush = 1'b0;
  logic        pc_hold;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifu #(.CPU_WIDTH(64), .INST_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .flush(flush), .pc_hold(pc_hold),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  // Memory contents and access faults are pure functions of the word address.
  function automatic logic [31:0] memData(input logic [63:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h0000_0013;
  endfunction

  function automatic logic memErr(input logic [63:0] a);
    return (a[6:2] == 5'd3);
  endfunction

  function automatic logic expFault(input logic [63:0] a);
    return (a[1:0] != 2'b00) || memErr(a);
  endfunction

  function automatic logic [31:0] expInst(input logic [63:0] a);
    return expFault(a) ? 32'h0 : memData(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstv, input logic [63:0] pcv, input logic fl,
                               input logic gn, input logic rv, input logic [31:0] rd,
                               input logic er, input logic rdy);
    @(negedge clk);
    rst_n       = rstv;
    pc          = pcv;
    flush       = fl;
    imem_gnt    = gn;
    imem_rvalid = rv;
    imem_rdata  = rd;
    imem_err    = er;
    inst_ready  = rdy;
    #1;
  endtask

  logic [63:0] pcM;
  logic [63:0] pendAddr;
  logic [63:0] savedAddr;
  bit          pending;
  bit          savedGnt, savedAcc, savedRv, savedStall;
  int          cnt, gntWait, idle, delivered;

  initial begin
    // Reset held for two cycles
    applyStimulus(0, P, 0, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, P, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_inst", inst, 0);
    checkOutput("rst_inst_pc", inst_pc, 0);
    checkOutput("rst_inst_fault", inst_fault, 0);
    checkOutput("rst_imem_req", imem_req, 0);
    checkOutput("rst_imem_addr", imem_addr, 0);
    checkOutput("rst_pc_hold", pc_hold, 1);

    // Basic fetch with two-cycle latency and immediate accept
    applyStimulus(1, P, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("idle_req", imem_req, 0);
    applyStimulus(1, P, 0, 1, 0, 32'h0, 0, 0);
    checkOutput("t1_req", imem_req, 1);
    checkOutput("t1_addr", imem_addr, P);
    applyStimulus(1, P, 0, 0, 1, 32'h0000_0413, 0, 1);
    checkOutput("t1_wait_valid", inst_valid, 0);
    checkOutput("t1_wait_hold", pc_hold, 1);
    applyStimulus(1, P, 0, 0, 0, 32'h0, 0, 1);
    checkOutput("t1_valid", inst_valid, 1);
    checkOutput("t1_inst", inst, 32'h0000_0413);
    checkOutput("t1_inst_pc", inst_pc, P);
    checkOutput("t1_pc_hold", pc_hold, 0);

    // Decode stalls three cycles before accepting
    applyStimulus(1, P + 4, 0, 1, 0, 32'h0, 0, 0);
    checkOutput("t2_after_valid", inst_valid, 0);
    checkOutput("t2_addr", imem_addr, P + 4);
    applyStimulus(1, P + 4, 0, 0, 1, 32'h00A0_0513, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, P + 4, 0, 0, 0, 32'h0, 0, 0);
      checkOutput("t2_stall_valid", inst_valid, 1);
      checkOutput("t2_stall_inst", inst, 32'h00A0_0513);
      checkOutput("t2_stall_inst_pc", inst_pc, P + 4);
      checkOutput("t2_stall_hold", pc_hold, 1);
      checkOutput("t2_stall_req", imem_req, 0);
    end
    applyStimulus(1, P + 4, 0, 0, 0, 32'h0, 0, 1);
    checkOutput("t2_accept_hold", pc_hold, 0);

    // Access fault from memory
    applyStimulus(1, P + 8, 0, 1, 0, 32'h0, 0, 0);
    checkOutput("t5_addr", imem_addr, P + 8);
    applyStimulus(1, P + 8, 0, 0, 1, 32'h1234_5678, 1, 0);
    applyStimulus(1, P + 8, 0, 0, 0, 32'h0, 0, 1);
    checkOutput("t5_valid", inst_valid, 1);
    checkOutput("t5_fault", inst_fault, 1);
    checkOutput("t5_inst", inst, 0);
    checkOutput("t5_inst_pc", inst_pc, P + 8);

    // Flush while waiting: stale data dropped, fetch restarts at target
    applyStimulus(1, P + 12, 0, 1, 0, 32'h0, 0, 0);
    checkOutput("t3_addr", imem_addr, P + 12);
    applyStimulus(1, P + 256, 1, 0, 0, 32'h0, 0, 0);
    checkOutput("t3_flush_hold", pc_hold, 0);
    applyStimulus(1, P + 256, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("t3_drop_req", imem_req, 0);
    applyStimulus(1, P + 256, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    checkOutput("t3_drop_valid", inst_valid, 0);
    applyStimulus(1, P + 256, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("t3_refetch_req", imem_req, 1);
    checkOutput("t3_refetch_addr", imem_addr, P + 256);
    checkOutput("t3_refetch_valid", inst_valid, 0);
    applyStimulus(1, P + 256, 0, 1, 0, 32'h0, 0, 0);
    applyStimulus(1, P + 256, 0, 0, 1, 32'h0010_0093, 0, 0);
    applyStimulus(1, P + 256, 0, 0, 0, 32'h0, 0, 1);
    checkOutput("t3_inst", inst, 32'h0010_0093);
    checkOutput("t3_inst_pc", inst_pc, P + 256);

    // Misaligned pc, then flush taking priority over ready in HOLD
    applyStimulus(1, P + 2, 1, 0, 0, 32'h0, 0, 0);
    checkOutput("t4_req", imem_req, 0);
    applyStimulus(1, P + 2, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("t4_valid", inst_valid, 1);
    checkOutput("t4_fault", inst_fault, 1);
    checkOutput("t4_inst", inst, 0);
    checkOutput("t4_inst_pc", inst_pc, P + 2);
    checkOutput("t4_hold", pc_hold, 1);
    applyStimulus(1, P + 512, 1, 0, 0, 32'h0, 0, 1);
    checkOutput("t4_flush_hold", pc_hold, 0);
    applyStimulus(1, P + 512, 0, 1, 0, 32'h0, 0, 0);
    checkOutput("t4_redirect_req", imem_req, 1);
    checkOutput("t4_redirect_addr", imem_addr, P + 512);
    checkOutput("t4_redirect_valid", inst_valid, 0);

    // Reset asserted while a read is outstanding
    applyStimulus(0, P + 512, 0, 0, 0, 32'h0, 0, 0);
    applyStimulus(1, P, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("t6_valid", inst_valid, 0);
    checkOutput("t6_req", imem_req, 0);
    checkOutput("t6_hold", pc_hold, 1);
    checkOutput("t6_inst_pc", inst_pc, 0);

    // Randomized run: bench acts as PC unit and memory
    pcM = P;
    pending = 0;
    pendAddr = '0;
    cnt = 0;
    gntWait = 0;
    idle = 0;
    delivered = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      flush = ($urandom_range(0, 9) == 0);
      if (flush) begin
        pcM = P + 64'($urandom_range(0, 255)) * 4;
        if ($urandom_range(0, 7) == 0) pcM = pcM + 64'($urandom_range(1, 3));
      end
      pc          = pcM;
      imem_rvalid = pending && (cnt == 0);
      imem_rdata  = imem_rvalid ? memData(pendAddr) : $urandom;
      imem_err    = imem_rvalid ? memErr(pendAddr) : 1'($urandom_range(0, 1));
      inst_ready  = 1'($urandom_range(0, 1));
      #1;
      imem_gnt = imem_req && (($urandom_range(0, 1) == 1) || (gntWait > 3));
      #1;
      checkOutput("pc_hold", pc_hold, !(inst_valid && inst_ready) && !flush);
      if (imem_req) begin
        checkOutput("req_addr", imem_addr, pcM);
        checkOutput("req_aligned", pcM[1:0], 0);
        checkOutput("one_outstanding", pending, 0);
      end
      if (inst_valid && !flush) begin
        checkOutput("inst_pc", inst_pc, pcM);
        checkOutput("inst", inst, expInst(pcM));
        checkOutput("inst_fault", inst_fault, expFault(pcM));
      end
      idle = inst_valid ? 0 : idle + 1;
      if (idle > 60) begin
        checkOutput("progress_idle_cycles", idle, 0);
        break;
      end
      savedGnt   = imem_req && imem_gnt;
      savedStall = imem_req && !imem_gnt;
      savedAddr  = imem_addr;
      savedAcc   = inst_valid && inst_ready && !flush;
      savedRv    = imem_rvalid;
      @(posedge clk);
      if (savedRv) pending = 0;
      else if (pending) cnt--;
      if (savedGnt) begin
        pending  = 1;
        pendAddr = savedAddr;
        cnt      = $urandom_range(0, 2);
      end
      gntWait = savedStall ? gntWait + 1 : 0;
      if (savedAcc) begin
        pcM = pcM + 4;
        delivered++;
      end
    end
    checkOutput("delivered_enough", delivered > 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
